// File: rtl/event_waiter_pkg.sv
// Shared types for the event waiter: FSM states and completion status codes.
package event_waiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ST_NONE is the reset value of done_status before any completion exists.
  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    HIT     = 2'b01,
    TIMEOUT = 2'b10,
    BAD_ID  = 2'b11
  } status_t;

endpackage

// File: rtl/event_pending_bank.sv
// Bank of sticky "triggered since last clear/consume" bits.
// A set and a clear on the same bit in the same cycle leaves the bit at 1,
// so a trigger is never lost to a concurrent clear.
module event_pending_bank #(
  parameter int NUM_EVENTS = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_EVENTS-1:0] set,
  input  logic [NUM_EVENTS-1:0] clr,
  output logic [NUM_EVENTS-1:0] pending
);

  // Set-wins update of every pending bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      pending <= (pending & ~clr) | set;
    end
  end

endmodule

// File: rtl/event_waiter.sv
// Consumer side of an event-trigger source: latches trigger pulses into
// pending bits, accepts one wait request at a time, and reports HIT, TIMEOUT
// or BAD_ID together with the timestamp of the cycle the outcome was decided.
module event_waiter
  import event_waiter_pkg::*;
#(
  parameter int NUM_EVENTS = 5,
  parameter int ID_W       = $clog2(NUM_EVENTS),
  parameter int TMO_W      = 16,
  parameter int TS_W       = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_EVENTS-1:0] ev_trig,
  input  logic [NUM_EVENTS-1:0] clr_pending,
  output logic [NUM_EVENTS-1:0] ev_pending,
  input  logic                  wait_valid,
  output logic                  wait_ready,
  input  logic [ID_W-1:0]       wait_id,
  input  logic                  wait_sticky,
  input  logic [TMO_W-1:0]      wait_timeout,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic [1:0]            done_status,
  output logic [TS_W-1:0]       done_ts
);

  state_t                  state;
  logic [ID_W-1:0]         id_q;
  logic                    sticky_q;
  logic [TMO_W-1:0]        timer;
  logic [TS_W-1:0]         ts;

  logic [NUM_EVENTS-1:0]   id_mask;
  logic                    hit;
  logic                    timeout_now;
  logic                    bad_id;
  logic [NUM_EVENTS-1:0]   consume;

  event_pending_bank #(
    .NUM_EVENTS (NUM_EVENTS)
  ) u_pending (
    .clk     (clk),
    .rstn    (rstn),
    .set     (ev_trig),
    .clr     (clr_pending | consume),
    .pending (ev_pending)
  );

  // Hit/timeout decision for the armed event; a sticky hit consumes its pending bit.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    id_mask     = NUM_EVENTS'(1) << id_q;
    hit         = 1'b0;
    consume     = '0;
    timeout_now = (timer == TMO_W'(1));
    bad_id      = (32'(wait_id) >= 32'(NUM_EVENTS));
    if (state == ARMED) begin
      hit = |(ev_trig & id_mask) || (sticky_q && |(ev_pending & id_mask));
      if (hit && sticky_q) begin
        consume = id_mask;
      end
    end
  end

  // Free-running cycle timestamp, wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  // Request FSM with timeout down-counter and registered handshake outputs.
  // timer==0 while ARMED means "wait forever"; it is loaded with T and the
  // timeout is declared in the armed cycle where it reads 1 (cycle A+T).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      wait_ready  <= 1'b1;
      done_valid  <= 1'b0;
      done_status <= ST_NONE;
      done_ts     <= '0;
      id_q        <= '0;
      sticky_q    <= 1'b0;
      timer       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wait_valid) begin
            wait_ready <= 1'b0;
            if (bad_id) begin
              state       <= DONE;
              done_valid  <= 1'b1;
              done_status <= BAD_ID;
              done_ts     <= ts;
            end else begin
              state    <= ARMED;
              id_q     <= wait_id;
              sticky_q <= wait_sticky;
              timer    <= wait_timeout;
            end
          end
        end
        ARMED: begin
          if (hit) begin
            state       <= DONE;
            done_valid  <= 1'b1;
            done_status <= HIT;
            done_ts     <= ts;
            timer       <= '0;
          end else if (timeout_now) begin
            state       <= DONE;
            done_valid  <= 1'b1;
            done_status <= TIMEOUT;
            done_ts     <= ts;
            timer       <= '0;
          end else if (timer != '0) begin
            timer <= timer - TMO_W'(1);
          end
        end
        DONE: begin
          if (done_ready) begin
            state      <= IDLE;
            done_valid <= 1'b0;
            wait_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          done_valid <= 1'b0;
          wait_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
